// File: rtl/jtag_uart_pkg.sv
// jtag_uart_pkg: register map, bit positions and FSM encoding shared by the JTAG UART stand-in
package jtag_uart_pkg;
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;
  localparam int RVALID_BIT = 15;
  localparam int RE_BIT = 0;
  localparam int WE_BIT = 1;
  localparam int RI_BIT = 8;
  localparam int WI_BIT = 9;
  localparam int AC_BIT = 10;
  localparam int CNT_LSB = 16;
  typedef enum logic {ST_IDLE, ST_RESP} state_e;
endpackage

// File: rtl/jtag_uart_slave_sync_fifo.sv
// sync_fifo: single-clock byte FIFO with occupancy count
module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/jtag_uart_slave.sv
// jtag_uart_slave: Avalon-MM JTAG UART stand-in with host-side TX/RX byte streams
module jtag_uart_slave
  import jtag_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int FIFO_AW = 6,
  parameter bit STALL_ON_FULL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        av_chipselect,
  input  logic        av_address,
  input  logic        av_read_n,
  input  logic        av_write_n,
  input  logic [31:0] av_writedata,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  logic [7:0] rx_head;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic rd, wr, wr_data, wr_ctrl, start_rd, stall;
  logic tx_push, tx_pop, rx_push, rx_pop, ri, wi;
  logic [31:0] data_word, ctrl_word;
  state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic pop_pend_q, pop_pend_d;
  logic re_q, re_d, we_q, we_d, ac_q, ac_d, irq_q, irq_d;
  logic unused_wdata;
  assign unused_wdata = ^{av_writedata[31:11], av_writedata[9:8]};
  assign rd = av_chipselect & ~av_read_n;
  assign wr = av_chipselect & av_read_n & ~av_write_n;
  assign wr_data = wr & (av_address == ADDR_DATA);
  assign wr_ctrl = wr & (av_address == ADDR_CTRL);
  assign start_rd = (state_q == ST_IDLE) & rd;
  assign stall = STALL_ON_FULL & wr_data & tx_full;
  assign tx_push = wr_data & ~tx_full;
  assign tx_pop = ~tx_empty & tx_ready;
  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop = (state_q == ST_RESP) & pop_pend_q;
  assign ri = re_q & ~rx_empty;
  assign wi = we_q & tx_empty;
  assign av_waitrequest = start_rd | stall;
  assign av_readdata = rdata_q;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign irq = irq_q;
  sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(av_writedata[7:0]),
    .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    data_word = '0;
    data_word[7:0] = rx_empty ? 8'h00 : rx_head;
    data_word[RVALID_BIT] = ~rx_empty;
    data_word[CNT_LSB +: 16] = 16'(rx_count - {{FIFO_AW{1'b0}}, ~rx_empty});
    ctrl_word = '0;
    ctrl_word[RE_BIT] = re_q;
    ctrl_word[WE_BIT] = we_q;
    ctrl_word[RI_BIT] = ri;
    ctrl_word[WI_BIT] = wi;
    ctrl_word[AC_BIT] = ac_q;
    ctrl_word[CNT_LSB +: 16] = 16'((FIFO_AW+1)'(FIFO_DEPTH) - tx_count);
  end
  // The RX pop is decided at capture time so the popped byte is the one the master sees
  always_comb begin
    state_d = start_rd ? ST_RESP : ST_IDLE;
    rdata_d = start_rd ? ((av_address == ADDR_DATA) ? data_word : ctrl_word) : rdata_q;
    pop_pend_d = start_rd & (av_address == ADDR_DATA) & ~rx_empty;
    re_d = wr_ctrl ? av_writedata[RE_BIT] : re_q;
    we_d = wr_ctrl ? av_writedata[WE_BIT] : we_q;
    ac_d = tx_pop | (ac_q & ~(wr_ctrl & av_writedata[AC_BIT]));
    irq_d = ri | wi;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      pop_pend_q <= 1'b0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      ac_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      pop_pend_q <= pop_pend_d;
      re_q <= re_d;
      we_q <= we_d;
      ac_q <= ac_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_jtag_uart_slave.sv
// tb_jtag_uart_slave: randomized bench against a queue-based model of the UART register interface
module tb_jtag_uart_slave;
  localparam int DEPTH = 64;
  logic clk, rst_n, cs, addr, read_n, write_n, write_n1, hold1, tx_ready, rx_valid;
  logic [31:0] wdata, av_readdata, av_readdata1;
  logic [7:0] rx_data, tx_data, tx_data1;
  logic av_waitrequest, av_waitrequest1, tx_valid, tx_valid1, rx_ready, rx_ready1, irq, irq1;
  logic [7:0] txq[$], rxq[$], q1[$];
  logic m_re, m_we, m_ac;
  logic [31:0] got;
  int total = 0, bad = 0;

  assign write_n1 = hold1 ? 1'b0 : write_n;

  jtag_uart_slave dut (
    .clk(clk), .rst_n(rst_n), .av_chipselect(cs), .av_address(addr), .av_read_n(read_n),
    .av_write_n(write_n), .av_writedata(wdata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );
  jtag_uart_slave #(.STALL_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .av_chipselect(cs), .av_address(addr), .av_read_n(read_n),
    .av_write_n(write_n1), .av_writedata(wdata), .av_readdata(av_readdata1),
    .av_waitrequest(av_waitrequest1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] g, logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, g, e);
    end
  endtask

  function automatic logic [31:0] exp_data();
    int n = rxq.size();
    logic rv = n != 0;
    return {16'(n - int'(rv)), rv, 7'b0, rv ? rxq[0] : 8'h00};
  endfunction

  function automatic logic [31:0] exp_ctrl();
    int n = txq.size();
    return {16'(DEPTH - n), 5'b0, m_ac, m_we & (n == 0), m_re & (rxq.size() != 0), 6'b0, m_we, m_re};
  endfunction

  function automatic logic exp_irq();
    return (m_re & (rxq.size() != 0)) | (m_we & (txq.size() == 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic a, logic [31:0] d);
    cs = 1'b1; addr = a; write_n = 1'b0; wdata = d;
    #1;
    chk("wr_wait", av_waitrequest, 0);
    step();
    cs = 1'b0; write_n = 1'b1;
    if (a == 1'b0) begin
      if (txq.size() < DEPTH) txq.push_back(d[7:0]);
    end else begin
      m_re = d[0];
      m_we = d[1];
      if (d[10]) m_ac = 1'b0;
    end
  endtask

  task automatic rd(logic a, output logic [31:0] g);
    cs = 1'b1; addr = a; read_n = 1'b0;
    #1;
    chk("rd_wait1", av_waitrequest, 1);
    step();
    chk("rd_wait0", av_waitrequest, 0);
    g = av_readdata;
    if (a) chk("rd_ctrl", g, exp_ctrl());
    else chk("rd_data", g, exp_data());
    cs = 1'b0; read_n = 1'b1;
    step();
    if (a == 1'b0 && rxq.size() != 0) void'(rxq.pop_front());
  endtask

  task automatic rxpush(logic [7:0] b);
    chk("rx_ready", rx_ready, rxq.size() < DEPTH);
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(b);
  endtask

  task automatic txpop();
    chk("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    if (txq.size() != 0) begin
      void'(txq.pop_front());
      m_ac = 1'b1;
    end
  endtask

  task automatic idle_irq();
    step();
    chk("irq", irq, exp_irq());
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; addr = 1'b0; read_n = 1'b1; write_n = 1'b1; wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; hold1 = 1'b0;
    m_re = 1'b0; m_we = 1'b0; m_ac = 1'b0;
    repeat (3) step();
    chk("rst_rdata", av_readdata, 0);
    chk("rst_wait", av_waitrequest, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_rxr", rx_ready, 1);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    step();
    rd(1'b0, got);
    chk("first_read", got, 32'h0);
    rd(1'b0, got);
    chk("no_pop_read", got, 32'h0);

    rxpush(8'h41);
    rxpush(8'h42);
    rd(1'b0, got);
    chk("read_41", got, 32'h00018041);
    rd(1'b0, got);
    chk("read_42", got, 32'h00008042);
    rd(1'b0, got);
    chk("read3_rvalid", got[15], 0);

    wr(1'b0, 32'h48);
    chk("tx48_valid", tx_valid, 1);
    chk("tx48_data", tx_data, 8'h48);
    rd(1'b1, got);
    chk("wspace63", got[31:16], 63);
    txpop();
    chk("tx_drained", tx_valid, 0);
    rd(1'b1, got);
    chk("ac_set", got[10], 1);

    for (int i = 0; i < DEPTH; i++) wr(1'b0, 32'(i + 1));
    rd(1'b1, got);
    chk("wspace0", got[31:16], 0);
    q1 = txq;
    cs = 1'b1; addr = 1'b0; write_n = 1'b0; wdata = 32'h5A;
    #1;
    chk("drop_wait", av_waitrequest, 0);
    chk("stall_wait", av_waitrequest1, 1);
    step();
    write_n = 1'b1; hold1 = 1'b1;
    #1;
    chk("stall_hold", av_waitrequest1, 1);
    step();
    chk("stall_hold2", av_waitrequest1, 1);
    chk("stall_head", tx_data1, q1[0]);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    void'(txq.pop_front());
    void'(q1.pop_front());
    m_ac = 1'b1;
    chk("stall_release", av_waitrequest1, 0);
    step();
    hold1 = 1'b0; cs = 1'b0;
    q1.push_back(8'h5A);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      chk("d0_valid", tx_valid, txq.size() != 0);
      if (txq.size() != 0) chk("d0_data", tx_data, txq[0]);
      chk("d1_valid", tx_valid1, q1.size() != 0);
      if (q1.size() != 0) chk("d1_data", tx_data1, q1[0]);
      step();
      if (txq.size() != 0) void'(txq.pop_front());
      if (q1.size() != 0) void'(q1.pop_front());
    end
    tx_ready = 1'b0;

    wr(1'b1, 32'h3);
    chk("irq_lag", irq, 0);
    idle_irq();
    chk("irq_wi", irq, 1);
    wr(1'b1, 32'h1);
    idle_irq();
    rxpush(8'h33);
    idle_irq();
    chk("irq_ri", irq, 1);
    rd(1'b0, got);
    idle_irq();
    chk("irq_clr", irq, 0);

    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0: for (int j = $urandom_range(1, 24); j > 0; j--) rxpush(8'($urandom()));
        1: for (int j = $urandom_range(1, 24); j > 0; j--) wr(1'b0, $urandom());
        2: for (int j = $urandom_range(1, 8); j > 0; j--) txpop();
        3: rd(1'b0, got);
        4: rd(1'b1, got);
        default: wr(1'b1, $urandom());
      endcase
      idle_irq();
    end

    for (int i = 0; i < 3; i++) rxpush(8'($urandom()));
    cs = 1'b1; addr = 1'b0; read_n = 1'b0;
    step();
    rst_n = 1'b0; cs = 1'b0; read_n = 1'b1;
    step();
    chk("mid_rst_wait", av_waitrequest, 0);
    chk("mid_rst_rdata", av_readdata, 0);
    chk("mid_rst_txv", tx_valid, 0);
    chk("mid_rst_rxr", rx_ready, 1);
    rst_n = 1'b1;
    rxq.delete(); txq.delete();
    m_re = 1'b0; m_we = 1'b0; m_ac = 1'b0;
    step();
    chk("post_rst_irq", irq, 0);
    rd(1'b0, got);
    chk("post_rst_read", got, 32'h0);
    rd(1'b1, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
